dial_seq_ctrl: RTL

Sequencer that owns the dial datapath for one puzzle input stream. It accepts rotation commands over a valid/ready handshake and buffers them in a small FIFO. It issues them one per cycle into the pipelined mod-100 reduction unit, with direction carried alongside, and applies each result to the 0..99 dial position. It counts the required zero events and returns the final count and position to the host-side reader through a result handshake.

---
 rtl/dial_pkg.sv | 32 +++
 rtl/dial_seq_ctrl_mod100_pipe.sv | 47 ++++
 rtl/dial_seq_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dial_pkg.sv
// dial_pkg: shared widths, FSM state type, command record and the
// mod-100 helper functions used by the dial sequencer and its pipe.
package dial_pkg;

  localparam int POS_W    = 7;
  localparam int AMT_W    = 32;
  localparam int CNT_W    = 32;
  localparam int DIAL_MOD = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             dir_r;
    logic [AMT_W-1:0] amt;
    logic             last;
  } cmd_t;

  // The remainder always fits in POS_W bits (0..99).
  function automatic logic [POS_W-1:0] amt_mod(input logic [AMT_W-1:0] a);
    return POS_W'(a % AMT_W'(DIAL_MOD));
  endfunction

  function automatic logic [AMT_W-1:0] amt_div(input logic [AMT_W-1:0] a);
    return a / AMT_W'(DIAL_MOD);
  endfunction

endpackage

// File: rtl/dial_seq_ctrl_mod100_pipe.sv
// mod100_pipe: LAT-stage pipeline returning amt mod 100 LAT cycles after
// the amount is presented. With DIAL_PASS_COUNT_EN defined it also returns
// amt / 100 on a parallel pipeline of identical depth.
// Ports: clk, rst (async, active-high), amt in, rem out [, quo out].
module mod100_pipe
  import dial_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] amt,
`ifdef DIAL_PASS_COUNT_EN
  output logic [AMT_W-1:0] quo,
`endif
  output logic [POS_W-1:0] rem
);

  logic [LAT-1:0][POS_W-1:0] rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q[0] <= amt_mod(amt);
      for (int i = 1; i < LAT; i++) rem_q[i] <= rem_q[i-1];
    end
  end

  assign rem = rem_q[LAT-1];

`ifdef DIAL_PASS_COUNT_EN
  logic [LAT-1:0][AMT_W-1:0] quo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
    end else begin
      quo_q[0] <= amt_div(amt);
      for (int i = 1; i < LAT; i++) quo_q[i] <= quo_q[i-1];
    end
  end

  assign quo = quo_q[LAT-1];
`endif

endmodule

// File: rtl/dial_seq_ctrl.sv
// dial_seq_ctrl: accepts rotation commands, buffers them in a DEPTH-entry
// FIFO, issues one per cycle into mod100_pipe and applies each remainder to
// the 0..99 dial position, counting zero events. The final count and
// position are offered on a res_valid/res_ready handshake.
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_dir_r/
// cmd_amt/cmd_last (command in); res_valid/res_ready, zero_count,
// final_pos (result out); busy.
// Option: DIAL_PASS_COUNT_EN counts every pass through 0, not just landings.
module dial_seq_ctrl
  import dial_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LAT       = 4,
  parameter int START_POS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir_r,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] zero_count,
  output logic [POS_W-1:0] final_pos,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]       state, state_nx;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             last_ret;

  // ---------------- command FIFO ----------------
  cmd_t          mem [DEPTH];
  cmd_t          cmd_in, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (occ == (AW+1)'(DEPTH));
  assign fifo_empty = (occ == '0);
  assign cmd_in     = '{dir_r: cmd_dir_r, amt: cmd_amt, last: cmd_last};
  assign push       = cmd_valid & cmd_ready;
  assign pop        = ~fifo_empty;  // the pipe never stalls
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // ---------------- issue pipe ----------------
  // Direction and last flag ride beside the remainder; index = cycles since pop.
  logic [LAT:1]     vld_pipe, dir_pipe, last_pipe;
  logic [POS_W-1:0] rem;
  logic             pipe_busy, upd, dir_o, last_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      dir_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= pop;
      dir_pipe[1]  <= head.dir_r;
      last_pipe[1] <= head.last;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        dir_pipe[i]  <= dir_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign pipe_busy = |vld_pipe;
  assign upd       = vld_pipe[LAT];
  assign dir_o     = dir_pipe[LAT];
  assign last_o    = last_pipe[LAT];

`ifdef DIAL_PASS_COUNT_EN
  logic [AMT_W-1:0] quo;
`endif

  mod100_pipe #(.LAT(LAT)) u_pipe (
    .clk (clk),
    .rst (rst),
    .amt (head.amt),
`ifdef DIAL_PASS_COUNT_EN
    .quo (quo),
`endif
    .rem (rem)
  );

  // ---------------- position update (8-bit intermediates) ----------------
  logic [7:0] p8, r8, s8, np8;

  always_comb begin
    p8 = {1'b0, pos};
    r8 = {1'b0, rem};
    s8 = p8 + r8;
    if (dir_o) np8 = (s8 >= 8'd100) ? s8 - 8'd100 : s8;
    else       np8 = (p8 >= r8) ? p8 - r8 : p8 + 8'd100 - r8;
  end

`ifdef DIAL_PASS_COUNT_EN
  // The +1 for reaching 0 already covers an exact landing.
  logic cross;
  assign cross   = dir_o ? (s8 >= 8'd100) : ((p8 != 8'd0) && (r8 >= p8));
  assign cnt_inc = CNT_W'(quo) + CNT_W'(cross);
`else
  assign cnt_inc = CNT_W'(np8 == 8'd0);
`endif

  // ---------------- control FSM ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (push) state_nx = cmd_last ? S_DRAIN : S_RUN;
      S_RUN:   if (push && cmd_last) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_empty && !pipe_busy && last_ret) state_nx = S_DONE;
      S_DONE:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pos      <= POS_W'(START_POS);
      cnt      <= '0;
      last_ret <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && push) begin
        pos      <= POS_W'(START_POS);
        cnt      <= '0;
        last_ret <= 1'b0;
      end else if (upd) begin
        pos <= POS_W'(np8);
        cnt <= cnt + cnt_inc;
        if (last_o) last_ret <= 1'b1;
      end
      if (state == S_DONE && res_ready) begin
        pos      <= POS_W'(START_POS);
        last_ret <= 1'b0;
      end
    end
  end

  // Ready is gated by rst so nothing is offered while reset is held.
  always_comb begin
    cmd_ready = 1'b0;
    if (!rst) begin
      if (state == S_IDLE)     cmd_ready = 1'b1;
      else if (state == S_RUN) cmd_ready = ~fifo_full;
    end
  end

  assign res_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign zero_count = cnt;
  assign final_pos  = pos;

endmodule
